// File: rtl/conv_cfg_pkg.sv
// Shared definitions for the sliding-window address generator.
//   conv_cfg_t  : captured layer configuration
//   gen_state_t : generator FSM states
//   cfg_invalid : configuration rejection check done at start accept
package conv_cfg_pkg;

    localparam int unsigned DEF_NUM_BANKS   = 8;
    localparam int unsigned DEF_BANK_ADDR_W = 16;
    localparam int unsigned DEF_DIM_W       = 10;
    localparam int unsigned DEF_CH_W        = 10;
    localparam int unsigned DEF_KS_W        = 4;
    localparam int unsigned DEF_ST_W        = 3;
    localparam int unsigned DEF_LIN_W       = DEF_BANK_ADDR_W + $clog2(DEF_NUM_BANKS);

    // Loop nest levels, innermost first.
    localparam int unsigned LOOP_LEVELS = 5;
    localparam int unsigned LVL_KX      = 0;
    localparam int unsigned LVL_KY      = 1;
    localparam int unsigned LVL_C       = 2;
    localparam int unsigned LVL_OX      = 3;
    localparam int unsigned LVL_OY      = 4;

    typedef struct packed {
        logic [DEF_KS_W-1:0]  kernel_size;
        logic [DEF_ST_W-1:0]  stride;
        logic [DEF_CH_W-1:0]  channel;
        logic [DEF_DIM_W-1:0] in_width;
        logic [DEF_DIM_W-1:0] in_height;
        logic [DEF_LIN_W-1:0] base_addr;
    } conv_cfg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    function automatic logic cfg_invalid(input conv_cfg_t cfg);
        return (cfg.kernel_size == '0) ||
               (cfg.stride == '0) ||
               (cfg.channel == '0) ||
               (DEF_DIM_W'(cfg.kernel_size) > cfg.in_width) ||
               (DEF_DIM_W'(cfg.kernel_size) > cfg.in_height);
    endfunction

endpackage

// File: rtl/conv_window_addr_gen_nested_loop_counter.sv
// Cascaded loop counter: LEVELS counters, level 0 innermost.
// Each level steps by step[i] and wraps to 0 once value+step would exceed
// limit[i]. The per-level "last" flag is registered alongside the value.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : load all levels with 0 (limits/steps must be valid this cycle)
//   advance   : step the innermost level, carrying outward
//   limit,step: per-level bound and increment
//   last      : level i holds its final value
//   carry     : carry[i] = level i steps this cycle; carry[LEVELS] = whole nest wrapped
module nested_loop_counter #(
    parameter int unsigned LEVELS = 5,
    parameter int unsigned CW     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       advance,
    input  logic [LEVELS-1:0][CW-1:0]  limit,
    input  logic [LEVELS-1:0][CW-1:0]  step,
    output logic [LEVELS-1:0]          last,
    output logic [LEVELS:0]            carry
);

    logic [LEVELS-1:0][CW-1:0] value;
    logic [LEVELS-1:0][CW-1:0] value_nxt;
    logic [LEVELS-1:0]         last_nxt;

    always_comb begin
        carry     = '0;
        value_nxt = value;
        last_nxt  = last;
        carry[0]  = advance;
        for (int unsigned i = 0; i < LEVELS; i++) begin
            carry[i+1] = carry[i] & last[i];
            if (clear) begin
                value_nxt[i] = '0;
            end else if (carry[i]) begin
                value_nxt[i] = last[i] ? '0 : value[i] + step[i];
            end
            // Extra bit keeps value+step from overflowing the compare.
            last_nxt[i] = ({1'b0, value_nxt[i]} + {1'b0, step[i]}) > {1'b0, limit[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            last  <= '0;
        end else if (clear || advance) begin
            value <= value_nxt;
            last  <= last_nxt;
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Sliding-window read address generator for the banked input feature-map SRAM.
// Streams one (bank, bank address) request per input element of every kernel
// window, loop order oy, ox, c, ky, kx, over a valid/ready handshake.
//   clk, rst         : clock, asynchronous active-low reset
//   start            : start request, sampled only in IDLE
//   kernel_size, stride, channel, in_width, in_height, base_addr : layer config
//   busy             : run in progress
//   addr_valid/ready : request handshake
//   bank_sel         : target bank (low bits of linear index)
//   bank_addr        : address inside bank (high bits of linear index)
//   last_of_window   : last request of the current output position
//   done, cfg_err    : completion pulse; cfg_err qualifies a rejected config
module conv_window_addr_gen
    import conv_cfg_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = DEF_NUM_BANKS,
    parameter int unsigned BANK_ADDR_W = DEF_BANK_ADDR_W,
    parameter int unsigned DIM_W       = DEF_DIM_W,
    parameter int unsigned CH_W        = DEF_CH_W,
    parameter int unsigned KS_W        = DEF_KS_W,
    parameter int unsigned ST_W        = DEF_ST_W
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [KS_W-1:0]                            kernel_size,
    input  logic [ST_W-1:0]                            stride,
    input  logic [CH_W-1:0]                            channel,
    input  logic [DIM_W-1:0]                           in_width,
    input  logic [DIM_W-1:0]                           in_height,
    input  logic [BANK_ADDR_W+$clog2(NUM_BANKS)-1:0]   base_addr,
    output logic                                       busy,
    output logic                                       addr_valid,
    input  logic                                       addr_ready,
    output logic [$clog2(NUM_BANKS)-1:0]               bank_sel,
    output logic [BANK_ADDR_W-1:0]                     bank_addr,
    output logic                                       last_of_window,
    output logic                                       done,
    output logic                                       cfg_err
);

    localparam int unsigned SEL_W = $clog2(NUM_BANKS);
    localparam int unsigned LIN_W = BANK_ADDR_W + SEL_W;
    localparam int unsigned CW    = (DIM_W > CH_W) ? DIM_W : CH_W;

    gen_state_t state;
    conv_cfg_t  cfg_q;
    conv_cfg_t  cfg_in;
    conv_cfg_t  cfg_use;

    logic [LIN_W-1:0] plane_q;
    logic [LIN_W-1:0] sw_q;
    logic [LIN_W-1:0] l_q;

    // Offsets (relative to base) at the start of each loop level.
    logic [LIN_W-1:0] off_l, off_ky, off_c, off_ox, off_oy;
    logic [LIN_W-1:0] nxt_l, nxt_ky, nxt_c, nxt_ox, nxt_oy;

    logic busy_q, valid_q, done_q, err_q;
    logic accept, hs, final_hs;

    logic [LOOP_LEVELS-1:0][CW-1:0] lim, stp;
    logic [LOOP_LEVELS-1:0]         lvl_last;
    logic [LOOP_LEVELS:0]           lvl_carry;
    logic [LOOP_LEVELS-1:0]         lvl_inc;

    always_comb begin
        cfg_in             = '0;
        cfg_in.kernel_size = DEF_KS_W'(kernel_size);
        cfg_in.stride      = DEF_ST_W'(stride);
        cfg_in.channel     = DEF_CH_W'(channel);
        cfg_in.in_width    = DEF_DIM_W'(in_width);
        cfg_in.in_height   = DEF_DIM_W'(in_height);
        cfg_in.base_addr   = DEF_LIN_W'(base_addr);
    end

    // The counter loads its first "last" flags on the accept cycle, before
    // cfg_q holds the new layer, so it sees the live inputs while in IDLE.
    assign cfg_use = (state == IDLE) ? cfg_in : cfg_q;

    assign accept   = (state == IDLE) && start;
    assign hs       = valid_q && addr_ready;
    assign final_hs = lvl_carry[LOOP_LEVELS];
    assign lvl_inc  = lvl_carry[LOOP_LEVELS-1:0] & ~lvl_last;

    // Origin positions ox*S / oy*S are bounded by W-K / H-K.
    always_comb begin
        lim = '0;
        stp = '0;
        lim[LVL_KX] = CW'(cfg_use.kernel_size) - CW'(1);
        lim[LVL_KY] = CW'(cfg_use.kernel_size) - CW'(1);
        lim[LVL_C]  = CW'(cfg_use.channel) - CW'(1);
        lim[LVL_OX] = CW'(cfg_use.in_width) - CW'(cfg_use.kernel_size);
        lim[LVL_OY] = CW'(cfg_use.in_height) - CW'(cfg_use.kernel_size);
        stp[LVL_KX] = CW'(1);
        stp[LVL_KY] = CW'(1);
        stp[LVL_C]  = CW'(1);
        stp[LVL_OX] = CW'(cfg_use.stride);
        stp[LVL_OY] = CW'(cfg_use.stride);
    end

    nested_loop_counter #(
        .LEVELS (LOOP_LEVELS),
        .CW     (CW)
    ) u_loops (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance (hs),
        .limit   (lim),
        .step    (stp),
        .last    (lvl_last),
        .carry   (lvl_carry)
    );

    // The outermost level that steps without wrapping sets the new offset;
    // every inner level restarts from that same offset.
    always_comb begin
        nxt_l  = off_l;
        nxt_ky = off_ky;
        nxt_c  = off_c;
        nxt_ox = off_ox;
        nxt_oy = off_oy;
        if (state == IDLE) begin
            nxt_l  = '0;
            nxt_ky = '0;
            nxt_c  = '0;
            nxt_ox = '0;
            nxt_oy = '0;
        end else if (lvl_inc[LVL_OY]) begin
            nxt_oy = off_oy + sw_q;
            nxt_ox = nxt_oy;
            nxt_c  = nxt_oy;
            nxt_ky = nxt_oy;
            nxt_l  = nxt_oy;
        end else if (lvl_inc[LVL_OX]) begin
            nxt_ox = off_ox + LIN_W'(cfg_q.stride);
            nxt_c  = nxt_ox;
            nxt_ky = nxt_ox;
            nxt_l  = nxt_ox;
        end else if (lvl_inc[LVL_C]) begin
            nxt_c  = off_c + plane_q;
            nxt_ky = nxt_c;
            nxt_l  = nxt_c;
        end else if (lvl_inc[LVL_KY]) begin
            nxt_ky = off_ky + LIN_W'(cfg_q.in_width);
            nxt_l  = nxt_ky;
        end else if (lvl_inc[LVL_KX]) begin
            nxt_l  = off_l + LIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cfg_q   <= '0;
            plane_q <= '0;
            sw_q    <= '0;
            l_q     <= '0;
            off_l   <= '0;
            off_ky  <= '0;
            off_c   <= '0;
            off_ox  <= '0;
            off_oy  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            off_l  <= nxt_l;
            off_ky <= nxt_ky;
            off_c  <= nxt_c;
            off_ox <= nxt_ox;
            off_oy <= nxt_oy;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_q   <= cfg_in;
                        plane_q <= LIN_W'(in_width) * LIN_W'(in_height);
                        sw_q    <= LIN_W'(stride) * LIN_W'(in_width);
                        if (cfg_invalid(cfg_in)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b1;
                            l_q     <= LIN_W'(base_addr);
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (final_hs) begin
                            state   <= DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            l_q     <= '0;
                        end else begin
                            l_q <= LIN_W'(cfg_q.base_addr) + nxt_l;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign addr_valid     = valid_q;
    assign done           = done_q;
    assign cfg_err        = err_q;
    assign bank_sel       = l_q[SEL_W-1:0];
    assign bank_addr      = l_q[LIN_W-1:SEL_W];
    assign last_of_window = valid_q & lvl_last[LVL_KX] & lvl_last[LVL_KY] & lvl_last[LVL_C];

endmodule
